vga_timing_gen: RTL and testbench

Parametrised VGA timing generator; successor to the fixed 640x480 sync generator. It produces aligned hsync, vsync, display_on and the pixel coordinates, with programmable porch, sync and polarity parameters. It also provides a pixel-clock enable, line and frame start strobes, and an optional frame counter that replaces ad-hoc `posedge vsync` counters in pattern blocks. It sits between the top-level clock and reset and every pixel-pattern block in the design.

---
 rtl/vga_timing_gen.sv | 173 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator. A horizontal/vertical position
// counter pair advances one pixel per enabled clock. hsync, vsync and
// display_on are registered from the next-state coordinates, so they always
// describe the hpos/vpos shown in the same cycle, with no skew between them.
// Also provides line/frame start strobes and an optional frame counter.
//
// Optional feature macro:
//   VGA_TIMING_FRAME_CNT_EN  defined   -> o_frame_cnt is a real wrapping
//                                         completed-frame counter
//                            undefined -> o_frame_cnt tied to zero, no register
//
// Ports:
//   i_clk          system clock
//   i_reset        asynchronous, active-high reset
//   i_pix_en       pixel advance enable (tie high for one pixel per clock)
//   o_hsync        horizontal sync, active level HSYNC_POL
//   o_vsync        vertical sync, active level VSYNC_POL
//   o_display_on   high inside the visible H_DISPLAY x V_DISPLAY area
//   o_hpos         current pixel column
//   o_vpos         current line
//   o_line_start   one-clock strobe in the first cycle showing hpos == 0
//   o_frame_start  one-clock strobe in the first cycle showing (0,0)
//   o_frame_cnt    completed-frame counter, wraps modulo 2^FRAME_W
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_BOTTOM  = 10,
    parameter int V_SYNC    = 2,
    parameter int V_TOP     = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int POS_W     = 10,
    parameter int FRAME_W   = 10
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_pix_en,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_display_on,
    output logic [POS_W-1:0]   o_hpos,
    output logic [POS_W-1:0]   o_vpos,
    output logic               o_line_start,
    output logic               o_frame_start,
    output logic [FRAME_W-1:0] o_frame_cnt
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

    localparam logic [POS_W-1:0] C_H_LAST     = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] C_V_LAST     = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0] C_H_SYNC_BEG = POS_W'(H_DISPLAY + H_FRONT);
    localparam logic [POS_W-1:0] C_H_SYNC_END = POS_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [POS_W-1:0] C_V_SYNC_BEG = POS_W'(V_DISPLAY + V_BOTTOM);
    localparam logic [POS_W-1:0] C_V_SYNC_END = POS_W'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
    // One extra bit so a display width equal to 2^POS_W still compares correctly.
    localparam logic [POS_W:0]   C_H_DISP     = (POS_W+1)'(H_DISPLAY);
    localparam logic [POS_W:0]   C_V_DISP     = (POS_W+1)'(V_DISPLAY);

    if (H_TOTAL > (1 << POS_W)) begin : g_bad_h_total
        $error("vga_timing_gen: H total does not fit in POS_W bits");
    end
    if (V_TOTAL > (1 << POS_W)) begin : g_bad_v_total
        $error("vga_timing_gen: V total does not fit in POS_W bits");
    end

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [POS_W-1:0] r_hpos;
    logic [POS_W-1:0] r_vpos;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_display_on;
    logic             r_line_start;
    logic             r_frame_start;

    // ---------------------------------------------------------------------
    // Next-state coordinates and the sync/display decode of those
    // coordinates, so the registered flags land together with the position.
    // ---------------------------------------------------------------------
    logic             w_h_last;
    logic             w_v_last;
    logic             w_frame_wrap;
    logic [POS_W-1:0] w_hpos_nxt;
    logic [POS_W-1:0] w_vpos_nxt;
    logic             w_hsync_act;
    logic             w_vsync_act;
    logic             w_hsync_nxt;
    logic             w_vsync_nxt;
    logic             w_display_nxt;

    always_comb begin
        w_h_last     = (r_hpos == C_H_LAST);
        w_v_last     = (r_vpos == C_V_LAST);
        w_frame_wrap = w_h_last && w_v_last;

        w_hpos_nxt = r_hpos + POS_W'(1);
        w_vpos_nxt = r_vpos;
        if (w_h_last) begin
            w_hpos_nxt = '0;
            w_vpos_nxt = w_v_last ? '0 : r_vpos + POS_W'(1);
        end

        w_hsync_act   = (w_hpos_nxt >= C_H_SYNC_BEG) && (w_hpos_nxt <= C_H_SYNC_END);
        w_vsync_act   = (w_vpos_nxt >= C_V_SYNC_BEG) && (w_vpos_nxt <= C_V_SYNC_END);
        w_hsync_nxt   = w_hsync_act ? HSYNC_POL : ~HSYNC_POL;
        w_vsync_nxt   = w_vsync_act ? VSYNC_POL : ~VSYNC_POL;
        w_display_nxt = ({1'b0, w_hpos_nxt} < C_H_DISP) && ({1'b0, w_vpos_nxt} < C_V_DISP);
    end

    // ---------------------------------------------------------------------
    // Position, sync and strobe registers. Strobes are only raised by an
    // enabled wrap, so the reset-induced (0,0) never produces a pulse.
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hpos        <= '0;
            r_vpos        <= '0;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_display_on  <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (i_pix_en) begin
            r_hpos        <= w_hpos_nxt;
            r_vpos        <= w_vpos_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_display_on  <= w_display_nxt;
            r_line_start  <= w_h_last;
            r_frame_start <= w_frame_wrap;
        end else begin
            // Hold the raster; strobes must not repeat while stalled.
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Advances on the same edge that raises frame_start.
    logic [FRAME_W-1:0] r_frame_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_frame_cnt <= '0;
        end else if (i_pix_en && w_frame_wrap) begin
            r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
        end
    end

    assign o_frame_cnt = r_frame_cnt;
`else
    assign o_frame_cnt = '0;
`endif

    assign o_hpos        = r_hpos;
    assign o_vpos        = r_vpos;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_display_on  = r_display_on;
    assign o_line_start  = r_line_start;
    assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Four instances share clock, reset and pix_en:
//   0: default 640x480 timing, active-low syncs
//   1: default timing, active-high syncs
//   2: tiny horizontal (4/1/2/1) with default vertical, to reach vsync quickly
//   3: tiny frame H 4/1/2/1, V 3/1/1/1, FRAME_W=2
// A behavioural raster model per instance feeds a scoreboard queue every
// cycle; a vector table and hand sequences add fixed-value checks.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic en;

    logic [9:0] t_h  [4];
    logic [9:0] t_v  [4];
    logic [9:0] t_fc [4];
    logic       t_hs [4];
    logic       t_vs [4];
    logic       t_de [4];
    logic       t_ls [4];
    logic       t_fs [4];
    logic [1:0] fc3;
    assign t_fc[3] = {8'd0, fc3};

    vga_timing_gen #(.HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) u_d0 (
        .i_clk(clk), .i_reset(rst), .i_pix_en(en),
        .o_hsync(t_hs[0]), .o_vsync(t_vs[0]), .o_display_on(t_de[0]),
        .o_hpos(t_h[0]), .o_vpos(t_v[0]), .o_line_start(t_ls[0]),
        .o_frame_start(t_fs[0]), .o_frame_cnt(t_fc[0]));

    vga_timing_gen #(.HSYNC_POL(1'b1), .VSYNC_POL(1'b1)) u_d1 (
        .i_clk(clk), .i_reset(rst), .i_pix_en(en),
        .o_hsync(t_hs[1]), .o_vsync(t_vs[1]), .o_display_on(t_de[1]),
        .o_hpos(t_h[1]), .o_vpos(t_v[1]), .o_line_start(t_ls[1]),
        .o_frame_start(t_fs[1]), .o_frame_cnt(t_fc[1]));

    vga_timing_gen #(.H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1)) u_d2 (
        .i_clk(clk), .i_reset(rst), .i_pix_en(en),
        .o_hsync(t_hs[2]), .o_vsync(t_vs[2]), .o_display_on(t_de[2]),
        .o_hpos(t_h[2]), .o_vpos(t_v[2]), .o_line_start(t_ls[2]),
        .o_frame_start(t_fs[2]), .o_frame_cnt(t_fc[2]));

    vga_timing_gen #(.H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                     .V_DISPLAY(3), .V_BOTTOM(1), .V_SYNC(1), .V_TOP(1),
                     .FRAME_W(2)) u_d3 (
        .i_clk(clk), .i_reset(rst), .i_pix_en(en),
        .o_hsync(t_hs[3]), .o_vsync(t_vs[3]), .o_display_on(t_de[3]),
        .o_hpos(t_h[3]), .o_vpos(t_v[3]), .o_line_start(t_ls[3]),
        .o_frame_start(t_fs[3]), .o_frame_cnt(fc3));

    // Per-instance timing parameters for the model
    int P_HD [4] = '{640, 640, 4, 4};
    int P_HF [4] = '{16, 16, 1, 1};
    int P_HS [4] = '{96, 96, 2, 2};
    int P_HB [4] = '{48, 48, 1, 1};
    int P_VD [4] = '{480, 480, 480, 3};
    int P_VB [4] = '{10, 10, 10, 1};
    int P_VS [4] = '{2, 2, 2, 1};
    int P_VT [4] = '{33, 33, 33, 1};
    bit P_HP [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    bit P_VP [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int P_FW [4] = '{10, 10, 10, 2};

    typedef struct {
        int h; int v; bit hs; bit vs; bit de; bit ls; bit fs; int fc;
    } mst_t;
    mst_t m [4];

    typedef struct packed {
        logic [9:0] h; logic [9:0] v;
        logic hs; logic vs; logic de; logic ls; logic fs;
        logic [9:0] fc;
    } obs_t;

    typedef struct packed { logic [1:0] id; obs_t exp; } sb_t;
    sb_t sb_q [$];

    int checks   = 0;
    int failures = 0;

    // Scenario monitors
    int hs0_lo = 0, hs0_first = -1, hs0_last = -1, hs1_hi = 0;
    int de0_639 = -1, de0_640 = -1;
    int vs2_lo = 0, vs2_fv = -1, vs2_fh = -1, vs2_lv = -1, vs2_lh = -1, de2_cnt = 0;
    bit fs2_seen = 1'b0;
    int fc3_seen [4];
    int n3 = 0;
    int fs0_cnt = 0;

    function automatic void model_step(int d, bit r, bit e);
        int ht, vt, hb, vb;
        ht = P_HD[d] + P_HF[d] + P_HS[d] + P_HB[d];
        vt = P_VD[d] + P_VB[d] + P_VS[d] + P_VT[d];
        if (r) begin
            m[d].h = 0; m[d].v = 0; m[d].de = 1'b1;
            m[d].hs = !P_HP[d]; m[d].vs = !P_VP[d];
            m[d].ls = 1'b0; m[d].fs = 1'b0; m[d].fc = 0;
        end else if (e) begin
            if (m[d].h == ht - 1) begin
                m[d].h  = 0;
                m[d].ls = 1'b1;
                if (m[d].v == vt - 1) begin
                    m[d].v = 0; m[d].fs = 1'b1;
                end else begin
                    m[d].v = m[d].v + 1; m[d].fs = 1'b0;
                end
            end else begin
                m[d].h = m[d].h + 1; m[d].ls = 1'b0; m[d].fs = 1'b0;
            end
            hb = P_HD[d] + P_HF[d];
            vb = P_VD[d] + P_VB[d];
            m[d].hs = (m[d].h >= hb && m[d].h < hb + P_HS[d]) ? P_HP[d] : !P_HP[d];
            m[d].vs = (m[d].v >= vb && m[d].v < vb + P_VS[d]) ? P_VP[d] : !P_VP[d];
            m[d].de = (m[d].h < P_HD[d]) && (m[d].v < P_VD[d]);
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (m[d].fs) m[d].fc = (m[d].fc + 1) % (1 << P_FW[d]);
`endif
        end else begin
            m[d].ls = 1'b0; m[d].fs = 1'b0;
        end
    endfunction

    function automatic obs_t model_obs(int d);
        obs_t o;
        o.h = 10'(m[d].h); o.v = 10'(m[d].v);
        o.hs = m[d].hs; o.vs = m[d].vs; o.de = m[d].de;
        o.ls = m[d].ls; o.fs = m[d].fs; o.fc = 10'(m[d].fc);
        return o;
    endfunction

    function automatic obs_t dut_obs(int d);
        obs_t o;
        o.h = t_h[d]; o.v = t_v[d];
        o.hs = t_hs[d]; o.vs = t_vs[d]; o.de = t_de[d];
        o.ls = t_ls[d]; o.fs = t_fs[d]; o.fc = t_fc[d];
        return o;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic sb_check(input sb_t e);
        obs_t a;
        a = dut_obs(int'(e.id));
        checks++;
        if (a !== e.exp) begin
            failures++;
            $display("FAIL sb_dut%0d @%0t: got h=%0d v=%0d hs=%0b vs=%0b de=%0b ls=%0b fs=%0b fc=%0d, expected h=%0d v=%0d hs=%0b vs=%0b de=%0b ls=%0b fs=%0b fc=%0d",
                     e.id, $time, a.h, a.v, a.hs, a.vs, a.de, a.ls, a.fs, a.fc,
                     e.exp.h, e.exp.v, e.exp.hs, e.exp.vs, e.exp.de, e.exp.ls, e.exp.fs, e.exp.fc);
        end
    endtask

    // One clock: drive at negedge, predict, sample 1 time unit after posedge.
    task automatic tick(input bit r, input bit e);
        sb_t s;
        @(negedge clk);
        rst = r;
        en  = e;
        for (int d = 0; d < 4; d++) begin
            model_step(d, r, e);
            s.id  = 2'(d);
            s.exp = model_obs(d);
            sb_q.push_back(s);
        end
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) sb_check(sb_q.pop_front());

        if (t_fs[0]) fs0_cnt++;
        if (!r && e) begin
            if (t_v[0] == 10'd0) begin
                if (!t_hs[0]) begin
                    hs0_lo++;
                    if (hs0_first < 0) hs0_first = int'(t_h[0]);
                    hs0_last = int'(t_h[0]);
                end
                if (t_hs[1]) hs1_hi++;
                if (t_h[0] == 10'd639) de0_639 = int'(t_de[0]);
                if (t_h[0] == 10'd640) de0_640 = int'(t_de[0]);
            end
            if (!fs2_seen) begin
                if (!t_vs[2]) begin
                    vs2_lo++;
                    if (vs2_fv < 0) begin vs2_fv = int'(t_v[2]); vs2_fh = int'(t_h[2]); end
                    vs2_lv = int'(t_v[2]); vs2_lh = int'(t_h[2]);
                end
                if (t_de[2]) de2_cnt++;
                if (t_fs[2]) fs2_seen = 1'b1;
            end
            if (t_fs[3] && n3 < 4) begin
                fc3_seen[n3] = int'(t_fc[3]);
                n3++;
            end
        end
    endtask

    typedef struct { bit r; bit e; int h; int v; bit ls; bit fs; } vec_t;
    vec_t tbl [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset release then pix_en pattern 1,0,0,1 (instance 0 expectations)
        tbl[0] = '{r:1'b1, e:1'b1, h:0, v:0, ls:1'b0, fs:1'b0};
        tbl[1] = '{r:1'b0, e:1'b1, h:1, v:0, ls:1'b0, fs:1'b0};
        tbl[2] = '{r:1'b0, e:1'b1, h:2, v:0, ls:1'b0, fs:1'b0};
        tbl[3] = '{r:1'b0, e:1'b0, h:2, v:0, ls:1'b0, fs:1'b0};
        tbl[4] = '{r:1'b0, e:1'b0, h:2, v:0, ls:1'b0, fs:1'b0};
        tbl[5] = '{r:1'b0, e:1'b1, h:3, v:0, ls:1'b0, fs:1'b0};

        rst = 1'b0;
        en  = 1'b0;
        #2 rst = 1'b1;
        #2;
        // Async reset values before any clock edge
        chk("rst_hpos", int'(t_h[0]), 0);
        chk("rst_vpos", int'(t_v[0]), 0);
        chk("rst_de", int'(t_de[0]), 1);
        chk("rst_hsync_lowpol", int'(t_hs[0]), 1);
        chk("rst_vsync_lowpol", int'(t_vs[0]), 1);
        chk("rst_hsync_highpol", int'(t_hs[1]), 0);
        chk("rst_vsync_highpol", int'(t_vs[1]), 0);
        chk("rst_strobes", int'({t_ls[0], t_fs[0]}), 0);
        chk("rst_fcnt", int'(t_fc[0]), 0);

        for (int i = 0; i < 6; i++) begin
            tick(tbl[i].r, tbl[i].e);
            chk($sformatf("tbl%0d_hpos", i), int'(t_h[0]), tbl[i].h);
            chk($sformatf("tbl%0d_vpos", i), int'(t_v[0]), tbl[i].v);
            chk($sformatf("tbl%0d_ls", i), int'(t_ls[0]), int'(tbl[i].ls));
            chk($sformatf("tbl%0d_fs", i), int'(t_fs[0]), int'(tbl[i].fs));
        end

        // End of line 0 with a stall at hpos 799
        for (int i = 0; i < 2000 && m[0].h != 798; i++) tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        chk("eol_hpos", int'(t_h[0]), 799);
        chk("eol_ls", int'(t_ls[0]), 0);
        tick(1'b0, 1'b0);
        chk("stall1_hpos", int'(t_h[0]), 799);
        chk("stall1_ls", int'(t_ls[0]), 0);
        tick(1'b0, 1'b0);
        chk("stall2_hpos", int'(t_h[0]), 799);
        chk("stall2_ls", int'(t_ls[0]), 0);
        tick(1'b0, 1'b1);
        chk("wrap_hpos", int'(t_h[0]), 0);
        chk("wrap_vpos", int'(t_v[0]), 1);
        chk("wrap_ls", int'(t_ls[0]), 1);
        chk("wrap_fs", int'(t_fs[0]), 0);
        tick(1'b0, 1'b1);
        chk("after_wrap_ls", int'(t_ls[0]), 0);

        chk("hsync_low_cycles", hs0_lo, 96);
        chk("hsync_first_hpos", hs0_first, 656);
        chk("hsync_last_hpos", hs0_last, 751);
        chk("hsync_highpol_cycles", hs1_hi, 96);
        chk("de_at_639", de0_639, 1);
        chk("de_at_640", de0_640, 0);

        // Run instance 2 through a full frame for vsync / display_on extents
        for (int i = 0; i < 6000 && !fs2_seen; i++) tick(1'b0, 1'b1);
        chk("d2_frame_done", int'(fs2_seen), 1);
        chk("d2_vsync_cycles", vs2_lo, 16);
        chk("d2_vsync_first_v", vs2_fv, 490);
        chk("d2_vsync_first_h", vs2_fh, 0);
        chk("d2_vsync_last_v", vs2_lv, 491);
        chk("d2_vsync_last_h", vs2_lh, 7);
        chk("d2_display_cycles", de2_cnt, 1920);
        chk("d2_fs_vpos", int'(t_v[2]), 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("d2_fcnt", int'(t_fc[2]), 1);
`else
        chk("d2_fcnt", int'(t_fc[2]), 0);
`endif

        // Small frame counter wrap after four frames
        chk("d3_frames_seen", n3, 4);
        for (int i = 0; i < 4; i++) begin
`ifdef VGA_TIMING_FRAME_CNT_EN
            chk($sformatf("d3_fcnt_frame%0d", i + 1), fc3_seen[i], (i + 1) % 4);
`else
            chk($sformatf("d3_fcnt_frame%0d", i + 1), fc3_seen[i], 0);
`endif
        end

        // Randomised pix_en stalls
        for (int i = 0; i < 400; i++) tick(1'b0, ($urandom_range(0, 3) != 0));

        // Mid-line reset held for several clocks
        for (int i = 0; i < 1000 && m[0].h != 300; i++) tick(1'b0, 1'b1);
        chk("pre_rst_hpos", int'(t_h[0]), 300);
        begin
            int fs_before;
            fs_before = fs0_cnt;
            @(negedge clk);
            rst = 1'b1;
            #1;
            chk("midrst_hpos", int'(t_h[0]), 0);
            chk("midrst_vpos", int'(t_v[0]), 0);
            chk("midrst_hsync", int'(t_hs[0]), 1);
            chk("midrst_vsync", int'(t_vs[0]), 1);
            chk("midrst_de", int'(t_de[0]), 1);
            chk("midrst_fcnt", int'(t_fc[0]), 0);
            chk("midrst_d3_fcnt", int'(t_fc[3]), 0);
            for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
            tick(1'b0, 1'b1);
            chk("release_hpos", int'(t_h[0]), 1);
            chk("release_vpos", int'(t_v[0]), 0);
            chk("release_ls", int'(t_ls[0]), 0);
            tick(1'b0, 1'b1);
            chk("release2_hpos", int'(t_h[0]), 2);
            chk("no_fs_on_reset", fs0_cnt - fs_before, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
